two_tone_gen: RTL
=================

TWO_TONE_GEN -- requirements
Module: two_tone_gen

Interface
REQ-001 The module SHALL have parameter N, default 16: output sample width, Q1.15 signed.
REQ-002 The module SHALL have parameter DIV, default 16, legal range 4..65535: clocks per output sample.
REQ-003 The module SHALL have parameter PINC1, default 16'd410: 16-bit phase increment of tone 1.
REQ-004 The module SHALL have parameter PINC2, default 16'd1229: 16-bit phase increment of tone 2.
REQ-005 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The module SHALL have port enable, input, 1 bit: high lets the sample tick counter run.
REQ-008 The module SHALL have port out_ready, input, 1 bit: downstream (FIR filter) accepts data_out.
REQ-009 The module SHALL have port data_out, output, N bits: signed two-tone sample.
REQ-010 The module SHALL have port out_valid, output, 1 bit: data_out holds an unconsumed sample.
REQ-011 The module SHALL have port overrun, output, 1 bit: sticky flag, a sample was overwritten before being consumed.

Function
REQ-012 Tick counter: 0..DIV-1, increments only while enable=1, wraps at DIV-1; tick asserts for one cycle at the wrap; counter holds while enable=0.
REQ-013 Phase accumulators ph1/ph2: 16-bit, modulo 2^16; the sample n computed on tick n uses ph = n*PINC (first sample phase 0); both accumulators advance by PINC only on tick.
REQ-014 Sine lookup: 256-entry quarter-wave ROM, entry k = round(32767*sin(pi/2*(k+0.5)/256)), 16-bit signed; entry 0 = 101, entry 255 = 32767.
REQ-015 Quadrant fold: q = ph[15:14], idx = ph[13:6]; q0 -> +ROM[idx]; q1 -> +ROM[255-idx]; q2 -> -ROM[idx]; q3 -> -ROM[255-idx]; ph[5:0] ignored, no interpolation.
REQ-016 Sum: data = (s1 >>> 1) + (s2 >>> 1), arithmetic shift, 16-bit signed result; by construction no overflow and no saturation needed.
REQ-017 Pipeline: tick cycle t registers phases (stage 1); t+1 registers ROM/fold outputs (stage 2); t+2 registers sum into data_out and sets out_valid (stage 3); out_valid is observable from cycle t+3.
REQ-018 Handshake: transfer occurs on any rising edge with out_valid=1 and out_ready=1; out_valid clears after the transfer unless a new stage-3 load happens in the same cycle.
REQ-019 data_out SHALL remain stable while out_valid=1 and no new stage-3 load occurs.
REQ-020 Overrun: a stage-3 load while out_valid=1 and out_ready=0 replaces data_out, keeps out_valid=1 and sets overrun; a load coincident with a transfer is not an overrun.
REQ-021 overrun is cleared only by reset.
REQ-022 enable deasserted mid-pipeline: samples already ticked complete through stage 3; no new tick occurs; phases hold.

Reset
REQ-023 reset=0 at a rising edge SHALL zero the tick counter, ph1, ph2, all pipeline registers, data_out, out_valid and overrun.
REQ-024 Reset SHALL take priority over enable, tick and handshake, including mid-pipeline, where in-flight samples are discarded.
REQ-025 After release, the first tick SHALL occur DIV cycles after the first rising edge with reset=1 and enable=1, and SHALL use phase 0.

Verification
REQ-026 Reset: hold reset=0 for 3 clocks with enable=1 and out_ready=1 -> data_out=0, out_valid=0, overrun=0 throughout.
REQ-027 Phase 0: defaults, reset released, out_ready=1 -> first valid data_out=100 (50+50), out_valid pulses one cycle, DIV+3 cycles after release.
REQ-028 Quadrants: PINC1=PINC2=16384, out_ready=1 -> consecutive samples 100, 32766, -102, -32768, then repeat.
REQ-029 Overrun: out_ready=0 across two ticks -> second sample replaces the first, overrun=1; then out_ready=1 -> single transfer, overrun stays 1 until reset.
REQ-030 Enable stall: drop enable for 50 cycles mid-run -> no ticks; the next sample continues the phase sequence with no skip.
REQ-031 Long run vs model: defaults, 2000 samples, out_ready random 70% -> every transferred value bit-exact to a software model of REQ-013..016; overrun matches the model.

Source files
------------

// File: rtl/two_tone_gen.sv
// two_tone_gen: sum of two fixed-frequency sine tones, one sample every DIV clocks.
//
// A tick counter paces the output. On each tick both 16-bit phase
// accumulators are captured and advanced, the phases are folded into a
// 256-entry quarter-wave sine ROM, and the two half-scaled tones are summed
// into data_out. Output side uses a valid/ready handshake.
//
// Handshake: a sample transfers on any rising clk edge where out_valid=1 and
// out_ready=1. out_valid stays high and data_out holds steady until that
// transfer. A new sample arriving while the old one is still unconsumed
// replaces it and sets the sticky overrun flag (unless it coincides with a
// transfer, which is a normal hand-over).
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-low
//   enable     lets the tick counter run; in-flight samples still complete
//   out_ready  downstream accepts data_out
//   data_out   signed Q1.15 two-tone sample (N bits)
//   out_valid  data_out holds an unconsumed sample
//   overrun    sticky: a sample was overwritten before being consumed
module two_tone_gen #(
    parameter int          N     = 16,
    parameter int          DIV   = 16,
    parameter logic [15:0] PINC1 = 16'd410,
    parameter logic [15:0] PINC2 = 16'd1229
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         out_valid,
    output logic         overrun
);

    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    // Quarter-wave entry k = round(32767*sin(pi/2*(k+0.5)/256)), evaluated at
    // elaboration with Q30 fixed-point Taylor series (x^1..x^17 terms), which
    // is far more precise than the final rounding to an integer needs.
    function automatic logic [15:0] sine_entry(input longint k);
        longint x, x2, term, acc, d;
        // pi/2 in Q30 is 1686629713
        x    = (64'sd1686629713 * (64'sd2 * k + 64'sd1) + 64'sd256) / 64'sd512;
        x2   = (x * x) / 64'sd1073741824;
        term = x;
        acc  = x;
        for (longint i = 1; i <= 8; i++) begin
            d    = (64'sd2 * i) * (64'sd2 * i + 64'sd1);
            term = -((term * x2) / (64'sd1073741824 * d));
            acc  = acc + term;
        end
        return 16'((acc * 64'sd32767 + 64'sd536870912) / 64'sd1073741824);
    endfunction

    logic [15:0] rom [256];

    for (genvar k = 0; k < 256; k++) begin : g_rom
        localparam logic [15:0] VAL = sine_entry(64'(k));
        assign rom[k] = VAL;
    end

    // Tick counter and phase accumulators
    logic [CW-1:0] cnt;
    logic          tick;
    logic [15:0]   ph1, ph2;

    // Stage 1: captured phases (only the bits the ROM fold uses)
    logic          s1_v;
    logic [15:6]   s1_ph1, s1_ph2;

    // Stage 2: folded tone samples
    logic                 s2_v;
    logic signed [15:0]   s2_a, s2_b;

    // Quadrant fold: bit 14 mirrors the index, bit 15 negates the value.
    logic [7:0]         idx1, idx2;
    logic [15:0]        mag1, mag2;
    logic signed [15:0] fold1, fold2;
    logic signed [15:0] sum;

    always_comb begin
        idx1  = s1_ph1[14] ? ~s1_ph1[13:6] : s1_ph1[13:6];
        idx2  = s1_ph2[14] ? ~s1_ph2[13:6] : s1_ph2[13:6];
        mag1  = rom[idx1];
        mag2  = rom[idx2];
        fold1 = s1_ph1[15] ? -$signed(mag1) : $signed(mag1);
        fold2 = s1_ph2[15] ? -$signed(mag2) : $signed(mag2);
    end

    // Each half lies in [-16384, 16383], so the sum cannot overflow 16 bits.
    assign sum = (s2_a >>> 1) + (s2_b >>> 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            tick      <= 1'b0;
            ph1       <= '0;
            ph2       <= '0;
            s1_v      <= 1'b0;
            s1_ph1    <= '0;
            s1_ph2    <= '0;
            s2_v      <= 1'b0;
            s2_a      <= '0;
            s2_b      <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (enable) begin
                cnt <= (cnt == CNT_MAX) ? '0 : CW'(cnt + 1'b1);
            end
            // One-cycle pulse in the cycle after the counter wraps.
            tick <= enable && (cnt == CNT_MAX);

            s1_v <= tick;
            if (tick) begin
                s1_ph1 <= ph1[15:6];
                s1_ph2 <= ph2[15:6];
                ph1    <= ph1 + PINC1;
                ph2    <= ph2 + PINC2;
            end

            s2_v <= s1_v;
            if (s1_v) begin
                s2_a <= fold1;
                s2_b <= fold2;
            end

            if (s2_v) begin
                data_out  <= N'(sum);
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
